fifo_read_adapter: RTL

FIFO_READ_ADAPTER -- requirements
Module: fifo_read_adapter

---
 rtl/fifo_read_adapter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fifo_read_adapter.sv
// Read adapter between a fixed-latency upstream FIFO and a ready/valid sink, with a 2-entry skid buffer.
// Optional statistics counters are enabled by defining FIFO_READ_ADAPTER_STATS_EN.
module fifo_read_adapter #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  core_clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_out_valid,
  input  logic [DATA_WIDTH-1:0] fifo_out_data,
  output logic                  fifo_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_READ_ADAPTER_STATS_EN
  ,
  output logic [31:0]           word_count,
  output logic [31:0]           stall_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            lat_q, lat_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  discard_q, discard_d;
  logic                  pop_en;
  logic                  push;
  logic                  keep;
  logic                  xfer;
  logic                  lat_reach;
  logic [1:0]            occ_after;

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      lat_q     <= 3'd0;
      occ_q     <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      occ_q     <= occ_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    xfer      = out_valid && out_ready;
    occ_after = occ_q - {1'b0, xfer};
    // The count reaches READ_LATENCY on this cycle's increment: this WAIT cycle is the data slot.
    lat_reach = (({1'b0, lat_q} + 4'd1) == 4'(READ_LATENCY));
    state_d   = state_q;
    lat_d     = lat_q;
    pop_en    = 1'b0;
    push      = 1'b0;
    discard_d = discard_q | (flush && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !flush && (occ_after < 2'd2)) begin
          pop_en  = 1'b1;
          state_d = S_WAIT;
          lat_d   = 3'd0;
        end
      end
      S_WAIT: begin
        lat_d = lat_q + 3'd1;
        if (lat_reach) begin
          if (fifo_out_valid) push = 1'b1;
          else                state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (fifo_out_valid) push = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (push) begin
      state_d   = S_IDLE;
      discard_d = 1'b0;
    end
    keep = push && !discard_q && !flush;

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (xfer) buf0_d = buf1_q;
    if (keep) begin
      if (occ_after == 2'd0) buf0_d = fifo_out_data;
      else                   buf1_d = fifo_out_data;
    end
    occ_d = occ_after + {1'b0, keep};
    if (flush) occ_d = 2'd0;
  end

  // Gated by resetn so the pop is low throughout reset, not only after the first edge.
  assign fifo_pop  = pop_en && resetn;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;

`ifdef FIFO_READ_ADAPTER_STATS_EN
  logic [31:0] word_q, word_d;
  logic [31:0] stall_q, stall_d;

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      word_q  <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      word_q  <= word_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    word_d  = word_q + {31'd0, xfer};
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    if (flush) begin
      word_d  = 32'd0;
      stall_d = 32'd0;
    end
  end

  assign word_count  = word_q;
  assign stall_count = stall_q;
`endif

endmodule
